mic_level_meter: RTL and testbench
==================================

// Module: mic_level_meter
// PURPOSE
//  Consumes the sample buffer filled by the mic capture stage: on each frame-ready pulse, sweeps the
//  2^ADDR_WIDTH-entry sample RAM through its read port and computes the mean absolute amplitude.
//  Produces a LEVEL_WIDTH-bit bar height for the display stage.
//  Sits between the mic sample RAM (read side) and the VGA bar renderer.
// PARAMETERS
//  ADDR_WIDTH   3    sample RAM address width; frame length N = 2^ADDR_WIDTH samples
//  DATA_WIDTH   18   sample width, signed two's complement
//  LEVEL_WIDTH  8    output bar-height width (must be <= DATA_WIDTH-1)
//  DECAY_STEP   16   per-frame fall of displayed level (used only with LEVEL_DECAY_EN)
// PORTS
//  clk          in   1            system clock
//  rst          in   1            asynchronous, active-high reset
//  start        in   1            frame-ready pulse from capture stage (1 cycle)
//  rd_en        out  1            sample RAM read enable
//  rd_addr      out  ADDR_WIDTH   sample RAM read address
//  rd_data      in   DATA_WIDTH   sample RAM read data; valid 1 cycle after rd_en
//  busy         out  1            high while a frame sweep is in progress
//  level        out  LEVEL_WIDTH  current bar height; holds between frames
//  level_valid  out  1            1-cycle pulse when level updates
// BEHAVIOUR
//  - Reset (async, active-high): FSM=IDLE; rd_en, rd_addr, busy, level, level_valid, accumulator all 0.
//  - FSM: IDLE -> READ on start; READ -> DRAIN after address N-1 issued; DRAIN -> SCALE; SCALE -> IDLE.
//  - IDLE: start sampled high -> next cycle busy=1, rd_en=1, rd_addr=0.
//  - READ: rd_en=1 for exactly N consecutive cycles, rd_addr = 0..N-1 incrementing. No wrap beyond N-1.
//  - Each rd_data is accumulated the cycle after its rd_en.
//    DRAIN absorbs the final sample.
//  - SCALE: mean = acc >> ADDR_WIDTH; level <= mean[DATA_WIDTH-2 -: LEVEL_WIDTH]; level_valid=1.
//    busy drops with the return to IDLE.
//  - Latency: start at edge 0 -> level_valid high during cycle N+3; one sweep per accepted start.
//  - Arithmetic: abs(sample) is DATA_WIDTH-1 bits unsigned.
//    Most-negative input (1<<(DATA_WIDTH-1)) saturates to 2^(DATA_WIDTH-1)-1.
//    Accumulator is DATA_WIDTH-1+ADDR_WIDTH bits and never overflows.
//  - start while busy: ignored, not queued. start coincident with SCALE cycle: ignored.
//  - rst mid-sweep: immediate abort to reset values; no level_valid for the aborted frame.
//  - rd_data outside the 1-cycle-after-rd_en window is ignored.
// CONFIGURATION
//  LEVEL_DECAY_EN defined:
//    level <= max(new_level, level - DECAY_STEP), floor 0 (no underflow).
//    Gives slowly falling bars.
//  LEVEL_DECAY_EN undefined:
//    level <= new_level directly; DECAY_STEP unused.
// STRUCTURE
//  - Shared package/header audio_viz_pkg: FSM state encodings (IDLE/READ/DRAIN/SCALE).
//    Also holds default ADDR_WIDTH/DATA_WIDTH constants shared with the capture stage and renderer.
//  - One sub-module abs_sat (combinational signed->unsigned magnitude with saturation, DATA_WIDTH param).
//  - Remainder (FSM, address counter, accumulator, level register) stays in mic_level_meter.
// TESTING  (ADDR_WIDTH=3, DATA_WIDTH=18, LEVEL_WIDTH=8, DECAY_STEP=16; RAM model 1-cycle read)
//  1 Assert rst mid-run, hold 3 cycles -> all outputs 0, FSM IDLE, no level_valid.
//  2 RAM all 18'd1024, pulse start -> rd_addr 0..7 over 8 cycles.
//    Then level=2 with level_valid on cycle 11; busy low after.
//  3 RAM alternating +65536/-65536 -> level=128.
//  4 RAM all 18'h20000 (most negative) -> abs saturates 131071 -> level=255.
//  5 start pulses at cycles 0, 4 and 11 -> exactly one level_valid (cycle 11).
//    Third start accepted only after IDLE (second level_valid at cycle 23 if issued at cycle 12).
//  6 rst pulse at cycle 5 of sweep -> rd_en 0 immediately, level 0, no level_valid.
//    Next start gives correct result.
//  7 (LEVEL_DECAY_EN) frame at 128 then all-zero frame -> level 112, then 96.

Source files
------------

// File: rtl/audio_viz_pkg.sv
// Shared definitions for the audio visualiser pipeline: default sample
// geometry used by the capture stage, level meter and bar renderer, and the
// level-meter sweep FSM encoding.
package audio_viz_pkg;

    localparam int VIZ_ADDR_WIDTH = 3;
    localparam int VIZ_DATA_WIDTH = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        SCALE = 2'd3
    } meter_state_t;

endpackage

// File: rtl/abs_sat.sv
// Signed two's complement sample -> unsigned magnitude, one bit narrower.
// The most-negative code has no positive counterpart in that width and is
// clamped to the largest representable magnitude.
module abs_sat #(
    parameter int DATA_WIDTH = 18
) (
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-2:0] mag
);

    // Negate negative samples; clamp the single unrepresentable case.
    always_comb begin
        mag = din[DATA_WIDTH-2:0];
        if (din[DATA_WIDTH-1]) begin
            if (din[DATA_WIDTH-2:0] == '0) begin
                mag = '1;
            end else begin
                mag = ~din[DATA_WIDTH-2:0] + (DATA_WIDTH-1)'(1);
            end
        end
    end

endmodule

// File: rtl/mic_level_meter.sv
// Mic level meter: on each frame-ready pulse, sweeps the 2^ADDR_WIDTH-entry
// sample RAM, accumulates absolute amplitudes and publishes the mean as a
// LEVEL_WIDTH-bit bar height.
// Optional feature macro: LEVEL_DECAY_EN (displayed level falls by at most
// DECAY_STEP per frame instead of jumping straight down).
module mic_level_meter
    import audio_viz_pkg::*;
#(
    parameter int ADDR_WIDTH  = VIZ_ADDR_WIDTH,
    parameter int DATA_WIDTH  = VIZ_DATA_WIDTH,
    parameter int LEVEL_WIDTH = 8,
    parameter int DECAY_STEP  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    input  logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   busy,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   level_valid
);

    localparam int ACC_WIDTH = DATA_WIDTH - 1 + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = '1;
    localparam logic [LEVEL_WIDTH-1:0] DECAY     = LEVEL_WIDTH'(DECAY_STEP);
`ifdef LEVEL_DECAY_EN
    localparam bit DECAY_EN = 1'b1;
`else
    localparam bit DECAY_EN = 1'b0;
`endif

    meter_state_t           state;
    meter_state_t           state_nxt;
    logic                   accept;
    logic                   sample_valid;
    logic [DATA_WIDTH-2:0]  mag;
    logic [ACC_WIDTH-1:0]   acc;
    logic [LEVEL_WIDTH-1:0] new_level;
    logic [LEVEL_WIDTH-1:0] decayed;
    logic [LEVEL_WIDTH-1:0] level_nxt;

    abs_sat #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_abs_sat (
        .din (rd_data),
        .mag (mag)
    );

    // Start acceptance: only from IDLE, and not in the cycle the previous
    // result is being published, so a start coincident with the end of a
    // sweep is dropped rather than chained.
    always_comb begin
        accept = (state == IDLE) && start && !level_valid;
    end

    // Sweep FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sweep FSM next state and read-side outputs.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                rd_en = 1'b1;
                if (rd_addr == LAST_ADDR) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = SCALE;
            end
            SCALE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Read address counter: restarts at 0 on accept, stops at the last entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr <= '0;
        end else if (accept) begin
            rd_addr <= '0;
        end else if (rd_en && (rd_addr != LAST_ADDR)) begin
            rd_addr <= rd_addr + ADDR_WIDTH'(1);
        end
    end

    // Marks the cycle in which rd_data carries the sample requested last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= rd_en;
        end
    end

    // Magnitude accumulator; sized so N full-scale samples cannot overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (accept) begin
            acc <= '0;
        end else if (sample_valid) begin
            acc <= acc + ACC_WIDTH'(mag);
        end
    end

    // Mean scaling and optional peak-hold style decay of the displayed level.
    always_comb begin
        // mean = acc >> ADDR_WIDTH; the bar takes the top LEVEL_WIDTH bits of
        // the mean, which are also the top bits of the accumulator.
        new_level = acc[ACC_WIDTH-1 -: LEVEL_WIDTH];
        decayed   = (level > DECAY) ? (level - DECAY) : '0;
        level_nxt = new_level;
        if (DECAY_EN && (decayed > new_level)) begin
            level_nxt = decayed;
        end
    end

    // Level register and its update strobe, written once per completed sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level       <= '0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= (state == SCALE);
            if (state == SCALE) begin
                level <= level_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mic_level_meter.sv
// Self-checking bench for mic_level_meter (ADDR_WIDTH=3, DATA_WIDTH=18,
// LEVEL_WIDTH=8, DECAY_STEP=16) with a 1-cycle-latency sample RAM model.
// Cycle k of a run is the period following clock edge k-1; start driven in
// cycle c is sampled at edge c.
module tb_mic_level_meter;

    localparam int AW = 3;
    localparam int DW = 18;
    localparam int LW = 8;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic [LW-1:0] level;
    logic          level_valid;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:N-1];

    logic          obs_lv    [0:63];
    logic          obs_busy  [0:63];
    logic          obs_rden  [0:63];
    logic [AW-1:0] obs_addr  [0:63];
    logic [LW-1:0] obs_level [0:63];

    logic          imm_rden;
    logic          imm_busy;
    logic          imm_lv;
    logic [LW-1:0] imm_level;

    logic [LW-1:0] exp_q [$];
    int            exp_cyc_q [$];
    logic [LW-1:0] model_level = '0;
    int            pushed_n;

    mic_level_meter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .LEVEL_WIDTH (LW),
        .DECAY_STEP  (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .level       (level),
        .level_valid (level_valid)
    );

    always #5 clk = ~clk;

    // Sample RAM: data one cycle after rd_en, junk otherwise.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= DW'($urandom);
    end

    // Reference: mean absolute amplitude of mem, as bar height.
    function automatic logic [LW-1:0] model_frame(input logic [LW-1:0] prev);
        int sum = 0;
        int v, nl, d;
        for (int i = 0; i < N; i++) begin
            v = mem[i][DW-1] ? int'(mem[i]) - (1 << DW) : int'(mem[i]);
            if (v < 0) v = -v;
            if (v > (1 << (DW-1)) - 1) v = (1 << (DW-1)) - 1;
            sum += v;
        end
        nl = (sum / N) / (1 << (DW-1-LW));
`ifdef LEVEL_DECAY_EN
        d = (int'(prev) > 16) ? int'(prev) - 16 : 0;
        if (d > nl) nl = d;
`else
        d = int'(prev);
`endif
        return LW'(nl);
    endfunction

    // Drives one run of ncyc cycles with up to three start pulses and an
    // optional reset pulse; records outputs and scoreboard expectations.
    task automatic run(input int s0, input int s1, input int s2, input int ncyc,
                       input int rst_at, input int rst_len);
        int next_ok = 0;
        logic [LW-1:0] e;
        pushed_n = 0;
        for (int c = 0; c < ncyc; c++) begin
            start = (c == s0) || (c == s1) || (c == s2);
            if (start && c >= next_ok) begin
                e = model_frame(model_level);
                model_level = e;
                exp_q.push_back(e);
                exp_cyc_q.push_back(c + 11);
                pushed_n++;
                next_ok = c + 12;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            obs_lv[c+1]    = level_valid;
            obs_busy[c+1]  = busy;
            obs_rden[c+1]  = rd_en;
            obs_addr[c+1]  = rd_addr;
            obs_level[c+1] = level;
            if (c == rst_at) begin
                #2 rst = 1'b1;
                #1;
                imm_rden  = rd_en;
                imm_busy  = busy;
                imm_lv    = level_valid;
                imm_level = level;
                exp_q.delete();
                exp_cyc_q.delete();
                model_level = '0;
                pushed_n = 0;
                next_ok = 0;
            end
            if (rst_at >= 0 && c == rst_at + rst_len) begin
                #3 rst = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        if (rd_en !== 1'b0)       begin errors++; $display("FAIL reset_rd_en got=%0b exp=0", rd_en); end
        if (rd_addr !== '0)       begin errors++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
        if (level !== '0)         begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        if (level_valid !== 1'b0) begin errors++; $display("FAIL reset_level_valid got=%0b exp=0", level_valid); end
        rst = 1'b0;
        // reset asserted mid-sweep and held for 3 cycles
        for (int i = 0; i < N; i++) mem[i] = 18'd1024;
        run(0, -1, -1, 16, 4, 3);
        checks += 3;
        if (imm_rden !== 1'b0) begin errors++; $display("FAIL midrst_rd_en got=%0b exp=0", imm_rden); end
        if (imm_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0b exp=0", imm_busy); end
        if (imm_lv !== 1'b0)   begin errors++; $display("FAIL midrst_lv got=%0b exp=0", imm_lv); end
        for (int k = 6; k <= 8; k++) begin
            checks++;
            if (obs_busy[k] !== 1'b0 || obs_rden[k] !== 1'b0 || obs_addr[k] !== '0 || obs_level[k] !== '0)
            begin
                errors++;
                $display("FAIL midrst_hold cycle=%0d busy=%0b rd_en=%0b addr=%0d level=%0d exp all 0",
                         k, obs_busy[k], obs_rden[k], obs_addr[k], obs_level[k]);
            end
        end
        n = 0;
        for (int k = 1; k <= 16; k++) if (obs_lv[k]) n++;
        checks++;
        if (n != pushed_n) begin errors++; $display("FAIL midrst_no_valid got=%0d pulses exp=%0d", n, pushed_n); end
    endtask

    task automatic test_basic;
        int n, ec;
        logic [LW-1:0] e;
        for (int i = 0; i < N; i++) mem[i] = 18'd1024;
        run(0, -1, -1, 14, -1, 0);
        for (int k = 1; k <= N; k++) begin
            checks++;
            if (obs_rden[k] !== 1'b1 || obs_addr[k] !== AW'(k - 1)) begin
                errors++;
                $display("FAIL basic_read cycle=%0d rd_en=%0b addr=%0d exp rd_en=1 addr=%0d",
                         k, obs_rden[k], obs_addr[k], k - 1);
            end
        end
        checks += 4;
        if (obs_rden[9] !== 1'b0)  begin errors++; $display("FAIL basic_rd_en_stop got=%0b exp=0", obs_rden[9]); end
        if (obs_busy[1] !== 1'b1)  begin errors++; $display("FAIL basic_busy_rise got=%0b exp=1", obs_busy[1]); end
        if (obs_busy[10] !== 1'b1) begin errors++; $display("FAIL basic_busy_scale got=%0b exp=1", obs_busy[10]); end
        if (obs_busy[11] !== 1'b0) begin errors++; $display("FAIL basic_busy_drop got=%0b exp=0", obs_busy[11]); end
        n = 0;
        for (int k = 1; k <= 14; k++) if (obs_lv[k]) begin
            n++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL basic_sb unexpected level_valid cycle=%0d", k);
            end else begin
                e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
                if (obs_level[k] !== e || k != ec) begin
                    errors++;
                    $display("FAIL basic_sb got level=%0d cycle=%0d exp level=%0d cycle=%0d", obs_level[k], k, e, ec);
                end
            end
        end
        checks++;
        if (n != pushed_n) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", n, pushed_n); end
        exp_q.delete(); exp_cyc_q.delete();
    endtask

    // Shared body for single-frame amplitude patterns.
    task automatic test_pattern(input int kind);
        int n, ec;
        logic [LW-1:0] e;
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       mem[i] = (i % 2 == 0) ? 18'd65536 : 18'h30000;
                1:       mem[i] = 18'h20000;
                2:       mem[i] = 18'd0;
                default: mem[i] = 18'd65536;
            endcase
        end
        run(0, -1, -1, 14, -1, 0);
        n = 0;
        for (int k = 1; k <= 14; k++) if (obs_lv[k]) begin
            n++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL pattern%0d_sb unexpected level_valid cycle=%0d", kind, k);
            end else begin
                e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
                if (obs_level[k] !== e || k != ec) begin
                    errors++;
                    $display("FAIL pattern%0d_sb got level=%0d cycle=%0d exp level=%0d cycle=%0d",
                             kind, obs_level[k], k, e, ec);
                end
            end
        end
        checks++;
        if (n != pushed_n) begin errors++; $display("FAIL pattern%0d_count got=%0d exp=%0d", kind, n, pushed_n); end
        checks++;
        if (obs_level[14] !== model_level) begin
            errors++; $display("FAIL pattern%0d_hold got=%0d exp=%0d", kind, obs_level[14], model_level);
        end
        exp_q.delete(); exp_cyc_q.delete();
    endtask

    task automatic test_start_while_busy;
        int n, ec;
        logic [LW-1:0] e;
        for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) run(0, 4, 11, 26, -1, 0);
            else           run(0, 12, -1, 26, -1, 0);
            n = 0;
            for (int k = 1; k <= 26; k++) if (obs_lv[k]) begin
                n++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL busy_start%0d_sb unexpected level_valid cycle=%0d", pass, k);
                end else begin
                    e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
                    if (obs_level[k] !== e || k != ec) begin
                        errors++;
                        $display("FAIL busy_start%0d_sb got level=%0d cycle=%0d exp level=%0d cycle=%0d",
                                 pass, obs_level[k], k, e, ec);
                    end
                end
            end
            checks++;
            if (n != pushed_n) begin errors++; $display("FAIL busy_start%0d_count got=%0d exp=%0d", pass, n, pushed_n); end
            exp_q.delete(); exp_cyc_q.delete();
        end
    endtask

    task automatic test_reset_mid_sweep;
        int n, ec;
        logic [LW-1:0] e;
        for (int i = 0; i < N; i++) mem[i] = 18'd65536;
        run(0, -1, -1, 16, 5, 1);
        checks += 3;
        if (imm_rden !== 1'b0)  begin errors++; $display("FAIL abort_rd_en got=%0b exp=0", imm_rden); end
        if (imm_level !== '0)   begin errors++; $display("FAIL abort_level got=%0d exp=0", imm_level); end
        if (imm_busy !== 1'b0)  begin errors++; $display("FAIL abort_busy got=%0b exp=0", imm_busy); end
        n = 0;
        for (int k = 1; k <= 16; k++) if (obs_lv[k]) n++;
        checks++;
        if (n != pushed_n) begin errors++; $display("FAIL abort_no_valid got=%0d pulses exp=%0d", n, pushed_n); end
        for (int i = 0; i < N; i++) mem[i] = 18'd1024;
        run(0, -1, -1, 14, -1, 0);
        n = 0;
        for (int k = 1; k <= 14; k++) if (obs_lv[k]) begin
            n++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL abort_next_sb unexpected level_valid cycle=%0d", k);
            end else begin
                e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
                if (obs_level[k] !== e || k != ec) begin
                    errors++;
                    $display("FAIL abort_next_sb got level=%0d cycle=%0d exp level=%0d cycle=%0d",
                             obs_level[k], k, e, ec);
                end
            end
        end
        checks++;
        if (n != pushed_n) begin errors++; $display("FAIL abort_next_count got=%0d exp=%0d", n, pushed_n); end
        exp_q.delete(); exp_cyc_q.delete();
    endtask

    initial begin
        test_reset;
        test_basic;
        test_pattern(0);   // alternating +/-65536 -> 128
        test_pattern(1);   // most negative -> saturated 255
        test_start_while_busy;
        test_reset_mid_sweep;
        test_pattern(3);   // all 65536 -> 128
        test_pattern(2);   // all zero: 0, or 112 with decay
        test_pattern(2);   // all zero: 0, or 96 with decay
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
